// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: state encoding,
// default operand width and the iteration counter sizing rule.
package div_pkg;

    // Default operand/result width; one quotient bit is produced per CALC cycle.
    localparam int DIV_WIDTH = 32;

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } div_state_t;

    // The counter must be able to hold the value WIDTH itself,
    // hence one bit more than log2.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
// The pair {rem,quo} is shifted left by one bit. A trial subtraction of the
// divisor then decides whether the new quotient bit is 1 (keep the
// difference) or 0 (restore the shifted remainder).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] rem_shifted;
    logic [WIDTH:0] trial;

    // Shift, trial-subtract one bit wider than the operands, then keep or restore.
    always_comb begin
        rem_shifted = {rem, quo[WIDTH-1]};
        trial       = rem_shifted - {1'b0, divisor};
        rem_next    = rem_shifted[WIDTH-1:0];
        quo_next    = {quo[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            rem_next = trial[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider responding to the control FSM's divControl request.
// The unit divides the magnitudes of A and B with an unsigned restoring loop,
// one bit per cycle. A final FIX cycle applies the signs: the quotient
// truncates toward zero, and the remainder follows the dividend's sign.
// A zero divisor raises a one-cycle div0 pulse instead of starting.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             divControl,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             done,
    output logic             busy,
    output logic             div0
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t state;
    div_state_t next_state;

    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] divisor;
    logic             sign_q;
    logic             sign_r;
    logic [CW-1:0]    counter;

    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             b_zero;

    // Operand magnitudes use plain WIDTH-bit negation, so the most negative value maps onto itself.
    always_comb begin
        abs_a  = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
        abs_b  = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
        b_zero = (b_in == '0);
    end

    div_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .rem      (rem),
        .quo      (quo),
        .divisor  (divisor),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // State register; reset drops any division in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: start only on a non-zero divisor. Run WIDTH CALC steps, then one FIX step.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (divControl && !b_zero) begin
                    next_state = CALC;
                end
            end
            CALC: begin
                if (counter == LAST) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: latch operands on start, iterate in CALC, apply signs and publish in FIX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            sign_q  <= 1'b0;
            sign_r  <= 1'b0;
            counter <= '0;
            lo_out  <= '0;
            hi_out  <= '0;
            done    <= 1'b0;
            busy    <= 1'b0;
            div0    <= 1'b0;
        end else begin
            done <= 1'b0;
            div0 <= 1'b0;
            case (state)
                IDLE: begin
                    if (divControl) begin
                        if (b_zero) begin
                            div0 <= 1'b1;
                        end else begin
                            quo     <= abs_a;
                            divisor <= abs_b;
                            rem     <= '0;
                            sign_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                            sign_r  <= a_in[WIDTH-1];
                            counter <= '0;
                            busy    <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem     <= rem_next;
                    quo     <= quo_next;
                    counter <= counter + 1'b1;
                end
                FIX: begin
                    lo_out <= sign_q ? (~quo + 1'b1) : quo;
                    hi_out <= sign_r ? (~rem + 1'b1) : rem;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
